// File: rtl/array_27_port_ctrl_if.sv
// array_27_port_ctrl_if: write, read and response valid/ready channels
// master = pipeline side, slave = array_27_port_ctrl.
interface array_27_port_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 13
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready,
    output rd_valid, rd_addr,
    input  rd_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready,
    input  rd_valid, rd_addr,
    output rd_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready
  );
endinterface

// File: rtl/array_27_port_ctrl.sv
// array_27_port_ctrl: init sweep + write/read arbitration onto SRAM RW0.
// Ports: clock, reset_n, clear, busy_init, bus (slave), RW0_* macro port.
module array_27_port_ctrl #(
  parameter int            DEPTH      = 256,
  parameter int            AW         = 8,
  parameter int            DW         = 13,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  output logic                 busy_init,
  array_27_port_ctrl_if.slave  bus,
  output logic [AW-1:0]        RW0_addr,
  output logic                 RW0_en,
  output logic                 RW0_wmode,
  output logic [DW-1:0]        RW0_wdata,
  input  logic [DW-1:0]        RW0_rdata
);

  typedef enum logic [1:0] {
    BOOT,
    INIT,
    RUN
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic          run;
  logic          infl_q;
  logic          prio_q;
  logic [1:0]    fcnt_q;
  logic          wp_q, rp_q;
  logic [DW-1:0] mem_q [2];

  logic          rd_can;
  logic          rd_elig;
  logic          wr_go;
  logic          rd_go;
  logic          push;
  logic          pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BOOT: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        if (clear)
          cnt_d = '0;
        else if (cnt_q == AW'(DEPTH - 1))
          state_d = RUN;
        else
          cnt_d = cnt_q + 1'b1;
      end
      RUN: begin
        if (clear) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign run       = (state_q == RUN);
  assign busy_init = ~run;

  // Slots already owed to the response buffer: stored + one in flight.
  assign rd_can  = (fcnt_q + {1'b0, infl_q}) < 2'd2;
  assign rd_elig = run & bus.rd_valid & rd_can;

  assign bus.wr_ready = run & ~(rd_elig & prio_q);
  assign bus.rd_ready = run & rd_can & (~bus.wr_valid | prio_q);

  assign wr_go = bus.wr_valid & bus.wr_ready;
  assign rd_go = bus.rd_valid & bus.rd_ready;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wdata = '0;
    unique case (1'b1)
      (state_q == INIT): begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = cnt_q;
        RW0_wdata = INIT_VALUE;
      end
      wr_go: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = bus.wr_addr;
        RW0_wdata = bus.wr_data;
      end
      rd_go: begin
        RW0_en    = 1'b1;
        RW0_addr  = bus.rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= 1'b0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= rd_go;
      if (bus.wr_valid & rd_elig)
        prio_q <= ~prio_q;
    end
  end

  // Capture is independent of FSM state so a clear never drops a read.
  assign push = infl_q;
  assign pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q  <= '{default: '0};
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= RW0_rdata;
        wp_q        <= ~wp_q;
      end
      if (pop)
        rp_q <= ~rp_q;
      fcnt_q <= fcnt_q + 2'(push) - 2'(pop);
    end
  end

  assign bus.rsp_valid = (fcnt_q != 2'd0);
  assign bus.rsp_data  = bus.rsp_valid ? mem_q[rp_q] : '0;

  a_no_ovf: assert property (
    @(posedge clock) disable iff (!reset_n)
    !(push && !pop && fcnt_q == 2'd2)
  );

endmodule

// File: tb/tb_array_27_port_ctrl.sv
// tb_array_27_port_ctrl: directed bench with SRAM model and scoreboard.
// Compares DUT outputs against a cycle-level behavioural model.
module tb_array_27_port_ctrl;
  localparam int AW    = 8;
  localparam int DW    = 13;
  localparam int DEPTH = 256;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          clear = 1'b0;
  logic          busy_init;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;

  array_27_port_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  array_27_port_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .INIT_VALUE('0)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .clear(clear),
    .busy_init(busy_init),
    .bus(bus),
    .RW0_addr(RW0_addr),
    .RW0_en(RW0_en),
    .RW0_wmode(RW0_wmode),
    .RW0_wdata(RW0_wdata),
    .RW0_rdata(RW0_rdata)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = DW'(13'h1555 ^ i);
  always @(posedge clock)
    if (RW0_en) begin
      if (RW0_wmode) sram[RW0_addr] <= RW0_wdata;
      else           RW0_rdata      <= sram[RW0_addr];
    end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // Model: phase 0=boot 1=init 2=run; responses as a list of visible data.
  int            m_phase = 0;
  int            m_idx = 0;
  bit            m_prio_rd = 1'b0;
  bit            m_infl = 1'b0;
  logic [DW-1:0] m_infl_d = '0;
  logic [DW-1:0] m_vis [$];
  logic [DW-1:0] ref_mem [DEPTH];
  bit            e_wr = 1'b0;
  bit            e_rd = 1'b0;
  bit            e_can = 1'b0;

  always @(posedge clock or negedge reset_n) begin : mdl
    bit wgo, rgo;
    if (!reset_n) begin
      m_phase = 0; m_idx = 0; m_prio_rd = 0; m_infl = 0;
      m_vis.delete();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      wgo = bus.wr_valid && e_wr;
      rgo = bus.rd_valid && e_rd;
      if (m_phase == 2 && bus.wr_valid && bus.rd_valid && e_can)
        m_prio_rd = !m_prio_rd;
      if (m_vis.size() > 0 && bus.rsp_ready) void'(m_vis.pop_front());
      if (m_infl) m_vis.push_back(m_infl_d);
      m_infl = rgo;
      if (rgo) m_infl_d = ref_mem[bus.rd_addr];
      if (wgo) ref_mem[bus.wr_addr] = bus.wr_data;
      case (m_phase)
        0: begin m_phase = 1; m_idx = 0; end
        1: begin
          if (clear) m_idx = 0;
          else if (m_idx == DEPTH - 1) m_phase = 2;
          else m_idx++;
        end
        default: begin
          if (clear) begin
            m_phase = 1; m_idx = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
          end
        end
      endcase
    end
  end

  always @(negedge clock) begin : cmp
    bit wgo, rgo;
    if (!reset_n) begin
      e_wr = 0; e_rd = 0; e_can = 0;
      chk("rst_busy", 32'(busy_init), 32'd1);
      chk("rst_en", 32'(RW0_en), 32'd0);
      chk("rst_wmode", 32'(RW0_wmode), 32'd0);
      chk("rst_addr", 32'(RW0_addr), 32'd0);
      chk("rst_wdata", 32'(RW0_wdata), 32'd0);
      chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
      chk("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    end else begin
      e_can = (m_vis.size() + (m_infl ? 1 : 0)) < 2;
      e_wr = 0; e_rd = 0;
      if (m_phase == 2) begin
        if (bus.wr_valid && bus.rd_valid && e_can) begin
          e_wr = !m_prio_rd; e_rd = m_prio_rd;
        end else begin
          e_wr = 1; e_rd = e_can;
        end
      end
      wgo = bus.wr_valid && e_wr;
      rgo = bus.rd_valid && e_rd;
      chk("busy_init", 32'(busy_init), 32'(m_phase != 2));
      if (bus.wr_valid) chk("wr_ready", 32'(bus.wr_ready), 32'(e_wr));
      if (bus.rd_valid) chk("rd_ready", 32'(bus.rd_ready), 32'(e_rd));
      if (m_phase == 1) begin
        chk("init_en", 32'(RW0_en), 32'd1);
        chk("init_wmode", 32'(RW0_wmode), 32'd1);
        chk("init_addr", 32'(RW0_addr), 32'(m_idx));
        chk("init_wdata", 32'(RW0_wdata), 32'd0);
      end else if (wgo) begin
        chk("wr_en", 32'(RW0_en), 32'd1);
        chk("wr_wmode", 32'(RW0_wmode), 32'd1);
        chk("wr_addr", 32'(RW0_addr), 32'(bus.wr_addr));
        chk("wr_wdata", 32'(RW0_wdata), 32'(bus.wr_data));
      end else if (rgo) begin
        chk("rd_en", 32'(RW0_en), 32'd1);
        chk("rd_wmode", 32'(RW0_wmode), 32'd0);
        chk("rd_addr", 32'(RW0_addr), 32'(bus.rd_addr));
      end else begin
        chk("idle_en", 32'(RW0_en), 32'd0);
        chk("idle_addr", 32'(RW0_addr), 32'd0);
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vis.size() > 0));
      if (m_vis.size() > 0)
        chk("rsp_data", 32'(bus.rsp_data), 32'(m_vis[0]));
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    bus.wr_valid = 1; bus.wr_addr = a; bus.wr_data = d;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.wr_ready) break;
    end
    chk("wr_handshake", 32'(bus.wr_ready), 32'd1);
    @(posedge clock); #1;
    bus.wr_valid = 0;
  endtask

  task automatic rd_issue(input logic [AW-1:0] a);
    int k;
    bus.rd_valid = 1; bus.rd_addr = a;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.rd_ready) break;
    end
    chk("rd_handshake", 32'(bus.rd_ready), 32'd1);
    @(posedge clock); #1;
    bus.rd_valid = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [AW-1:0] a,
                        input logic [DW-1:0] exp);
    int k, t;
    bus.rd_valid = 1; bus.rd_addr = a;
    for (k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.rd_ready) break;
    end
    chk({nm, "_hs"}, 32'(bus.rd_ready), 32'd1);
    t = cyc;
    @(posedge clock); #1;
    bus.rd_valid = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.rsp_valid) break;
    end
    chk({nm, "_data"}, 32'(bus.rsp_data), 32'(exp));
    chk({nm, "_lat"}, 32'(cyc - t), 32'd2);
    @(posedge clock); #1;
  endtask

  task automatic wait_init(output int n, output int nrsp,
                           output logic [DW-1:0] last);
    n = 0; nrsp = 0; last = '0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clock);
      if (bus.rsp_valid && bus.rsp_ready) begin
        nrsp++; last = bus.rsp_data;
      end
      if (!busy_init) break;
      n++;
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int            n, nrsp, got, g, w, acc;
  logic [DW-1:0] last;
  logic [DW-1:0] rs [6];
  int            gs [6];

  initial begin
    bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 0; bus.rd_addr = '0; bus.rsp_ready = 1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1;

    @(negedge clock);
    chk("boot_en", 32'(RW0_en), 32'd0);
    chk("boot_busy", 32'(busy_init), 32'd1);
    wait_init(n, nrsp, last);
    chk("init_cycles", 32'(n), 32'd256);
    rd_chk("rd_ff", 8'hFF, 13'h0);

    wr(8'hA5, 13'h1ABC);
    rd_chk("rd_a5", 8'hA5, 13'h1ABC);

    wr(8'h01, 13'h011); wr(8'h02, 13'h022);
    wr(8'h03, 13'h033); wr(8'h04, 13'h044);
    bus.rsp_ready = 0; acc = 0; got = 0;
    bus.rd_valid = 1; bus.rd_addr = 8'h01;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clock);
      if (k == 8) begin
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_rd_ready", 32'(bus.rd_ready), 32'd0);
      end
      if (bus.rd_valid && bus.rd_ready) acc++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rs[got] = bus.rsp_data; got++;
      end
      @(posedge clock); #1;
      if (k == 8) bus.rsp_ready = 1;
      if (acc < 4) bus.rd_addr = AW'(acc + 1);
      else bus.rd_valid = 0;
    end
    bus.rd_valid = 0;
    chk("bp_count", 32'(got), 32'd4);
    chk("bp_rsp0", 32'(rs[0]), 32'h011);
    chk("bp_rsp1", 32'(rs[1]), 32'h022);
    chk("bp_rsp2", 32'(rs[2]), 32'h033);
    chk("bp_rsp3", 32'(rs[3]), 32'h044);

    g = 0; w = 0; got = 0;
    bus.wr_valid = 1; bus.wr_addr = 8'h10; bus.wr_data = 13'h0A0;
    bus.rd_valid = 1; bus.rd_addr = 8'h10;
    for (int k = 0; k < 40 && (g < 6 || got < 3); k++) begin
      @(negedge clock);
      if (g < 6 && bus.wr_valid && bus.wr_ready) begin
        gs[g] = 0; g++; w++;
      end else if (g < 6 && bus.rd_valid && bus.rd_ready) begin
        gs[g] = 1; g++;
      end
      if (bus.rsp_valid && got < 3) begin
        rs[got] = bus.rsp_data; got++;
      end
      @(posedge clock); #1;
      bus.wr_data = DW'(13'h0A0 + w);
      if (g >= 6) begin bus.wr_valid = 0; bus.rd_valid = 0; end
    end
    bus.wr_valid = 0; bus.rd_valid = 0;
    for (int i = 0; i < 6; i++)
      chk($sformatf("arb_grant%0d", i), 32'(gs[i]), 32'(i % 2));
    chk("arb_rsp0", 32'(rs[0]), 32'h0A0);
    chk("arb_rsp1", 32'(rs[1]), 32'h0A1);
    chk("arb_rsp2", 32'(rs[2]), 32'h0A2);

    wr(8'h30, 13'h0777);
    bus.rd_valid = 1; bus.rd_addr = 8'h30;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (bus.rd_ready) break;
    end
    chk("clr_rd_hs", 32'(bus.rd_ready), 32'd1);
    @(posedge clock); #1;
    bus.rd_valid = 0; clear = 1;
    @(posedge clock); #1;
    clear = 0;
    wait_init(n, nrsp, last);
    chk("clr_rsp_count", 32'(nrsp), 32'd1);
    chk("clr_rsp_data", 32'(last), 32'h0777);
    chk("clr_init_cycles", 32'(n), 32'd256);
    rd_chk("clr_reread", 8'h30, 13'h0);

    wr(8'h40, 13'h0555); wr(8'h41, 13'h0666);
    bus.rsp_ready = 0;
    rd_issue(8'h40);
    rd_issue(8'h41);
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_buffered", 32'(bus.rsp_valid), 32'd1);
    #2 reset_n = 0;
    #1;
    chk("rst_now_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_now_busy", 32'(busy_init), 32'd1);
    chk("rst_now_en", 32'(RW0_en), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1; bus.rsp_ready = 1;
    @(negedge clock);
    chk("reboot_en", 32'(RW0_en), 32'd0);
    chk("reboot_rsp", 32'(bus.rsp_valid), 32'd0);
    wait_init(n, nrsp, last);
    chk("reinit_cycles", 32'(n), 32'd256);
    chk("reinit_stale", 32'(nrsp), 32'd0);
    rd_chk("reinit_rd40", 8'h40, 13'h0);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
